sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Round-robin arbiter that shares the read/write port 0 (csb0/web0/wmask0/addr0/din0/dout0) of the single-port-RW SramUnit macro between NUM_REQ requesters. It uses a valid/ready request handshake and returns read data with a fixed latency, tagged to the originating requester. It sits between the SramUnit instance and its client blocks. Port 1 (read-only) is not touched by this block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, SRAM word width
ADDR_WIDTH, 10, SRAM address width (depth = 2**ADDR_WIDTH)
NUM_WMASKS, 4, write-mask bits (DATA_WIDTH/NUM_WMASKS bits per mask bit)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_we  in  NUM_REQ  1=write, 0=read
req_wmask  in  NUM_REQ*NUM_WMASKS  flattened write masks, requester i at slice i
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
resp_valid  out  NUM_REQ  one-hot read-response strobe
resp_rdata  out  DATA_WIDTH  read data, shared by all requesters
init_done  out  1  high once the arbiter accepts requests
sram_csb0  out  1  active-low chip select to the SRAM
sram_web0  out  1  active-low write enable
sram_wmask0  out  NUM_WMASKS  write mask
sram_addr0  out  ADDR_WIDTH  address
sram_din0  out  DATA_WIDTH  write data
sram_dout0  in  DATA_WIDTH  read data from the SRAM

Behaviour:
- Clocking and reset: single clk domain. rst is asynchronous and active-high.
- Reset values: sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, req_ready=0, resp_valid=0, resp_rdata=0, RR pointer=0. init_done reset value is defined under Optional Feature.
- FSM states: INIT, RUN. Reset enters INIT when SRAM_INIT_EN is defined, otherwise RUN.
- Grant (RUN only): combinational. The grant goes to the first requester with req_valid=1, searching upward from the pointer with wrap-around.
  - req_ready is high only for the granted requester. It may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - On a handshake by requester i, pointer <= (i+1) mod NUM_REQ. With no handshake the pointer holds.
- Command stage: on a handshake at edge E the SRAM output registers load: csb0=0, web0=~we, wmask, addr, din. Also loaded: requester id and a read flag.
  - With no handshake the next cycle has csb0=1, web0=1, wmask0=0; addr0/din0 hold their values.
- Response pipeline: the SRAM samples at E+1, and dout0 is valid in the following cycle. The arbiter registers dout0 into resp_rdata at E+2.
  - resp_valid[id] pulses for exactly one cycle after E+2, i.e. 3 cycles after the accept edge. Reads only; writes produce no response.
- Throughput: one accepted request per cycle. Requests are fully pipelined; no stall and no backpressure on responses.
- Write then read of the same address in back-to-back cycles returns the new data (SRAM ordering; the arbiter inserts no bubble).
- resp_rdata holds its value when resp_valid=0.
- Reset mid-operation: in-flight commands and responses are discarded. csb0 goes to 1 immediately (async), and no resp_valid follows after release.

Optional Feature:
Macro SRAM_INIT_EN.
- Defined:
  - After reset the FSM stays in INIT and writes zero to every address 0..2**ADDR_WIDTH-1, one per cycle: csb0=0, web0=0, wmask0 all ones, din0=0, addr0 = counter.
  - req_ready=0 throughout INIT.
  - After the last write is issued: state <= RUN and init_done <= 1. init_done resets to 0.
- Undefined: no INIT state and no counter. init_done is constant 1, including its reset value.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum typedef (INIT, RUN);
  - typedef struct for a command (we, wmask, addr, wdata, id);
  - localparam ID_WIDTH = $clog2(NUM_REQ), with a minimum of 1.
- Sub-module rr_arbiter: NUM_REQ parameter, valid vector in, one-hot grant plus index out, internal pointer register advanced on an accept input.

Test Plan:
1. SRAM_INIT_EN defined, release rst -> init_done=0, csb0=0/web0=0/din0=0 with addr0 stepping 0..1023 over 1024 cycles, then init_done=1 and req_ready can assert.
2. req0 writes addr 5, data 0xaaaaaaaa, wmask 4'b1111; then req0 reads addr 5 -> resp_valid=4'b...01 exactly 3 cycles after the read accept, resp_rdata=0xaaaaaaaa; no resp for the write.
3. Write 0xffffffff to addr 7, then 0x12345678 with wmask 4'b0001, then read addr 7 -> resp_rdata=0xffffff78.
4. req0 and req1 both hold valid, reading addr 1 (holds 0x11) and addr 2 (holds 0x22) -> grants alternate 0,1,0,1; responses alternate resp_valid[0] with 0x11 and resp_valid[1] with 0x22 on consecutive cycles.
5. Assert rst one cycle after a read accept -> sram_csb0=1 and resp_valid=0 immediately; no response after rst release.
6. No req_valid for 20 cycles in RUN -> sram_csb0 stays 1, web0=1, resp_valid=0, pointer unchanged.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port-0 round-robin arbiter.
package sram_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_NUM_WMASKS = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_WIDTH = id_width(DEF_NUM_REQ);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [DEF_NUM_WMASKS-1:0] wmask;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [ID_WIDTH-1:0]       id;
    } cmd_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake and SRAM port-0 bundle for sram_port_arbiter.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*NUM_WMASKS-1:0] req_wmask;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic                          init_done;
    logic                          sram_csb0;
    logic                          sram_web0;
    logic [NUM_WMASKS-1:0]         sram_wmask0;
    logic [ADDR_WIDTH-1:0]         sram_addr0;
    logic [DATA_WIDTH-1:0]         sram_din0;
    logic [DATA_WIDTH-1:0]         sram_dout0;

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, sram_dout0,
        output req_ready, resp_valid, resp_rdata, init_done,
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
    );

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, sram_dout0,
        input  req_ready, resp_valid, resp_rdata, init_done,
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or above the pointer, with wrap.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin
        int j;
        logic [ID_W-1:0] jj;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = ID_W'(j);
            if (!found && valid_i[jj]) begin
                found       = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) ptr_d = (idx_o == ID_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between NUM_REQ requesters; read data returns 3 edges after accept.
// Optional SRAM_INIT_EN: zero-fill every SRAM word after reset before accepting requests.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input logic              clk,
    input logic              rst,
    sram_port_arbiter_if.slave bus
);
    localparam int ID_W = id_width(NUM_REQ);

    logic                  run;
    logic [NUM_REQ-1:0]    arb_valid;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic                  csb_q, web_q;
    logic [NUM_WMASKS-1:0] wmask_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rd_p0, rd_p1;
    logic [ID_W-1:0]       id_p0, id_p1;
    logic [NUM_REQ-1:0]    resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

`ifdef SRAM_INIT_EN
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_done_q;
    assign run           = (state_q == RUN);
    assign bus.init_done = init_done_q;
`else
    // No grants while reset is held, so req_ready reads 0 during reset.
    assign run           = ~rst;
    assign bus.init_done = 1'b1;
`endif

    assign arb_valid     = bus.req_valid & {NUM_REQ{run}};
    assign accept        = |grant;
    assign bus.req_ready = grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (arb_valid),
        .accept_i (accept),
        .grant_o  (grant),
        .idx_o    (grant_idx)
    );

    // Command stage: SRAM pins are driven straight from these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rd_p0   <= 1'b0;
            id_p0   <= '0;
`ifdef SRAM_INIT_EN
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            rd_p0   <= 1'b0;
`ifdef SRAM_INIT_EN
            if (state_q == INIT) begin
                csb_q      <= 1'b0;
                web_q      <= 1'b0;
                wmask_q    <= '1;
                din_q      <= '0;
                addr_q     <= init_cnt_q;
                init_cnt_q <= init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_q     <= RUN;
                    init_done_q <= 1'b1;
                end
            end else
`endif
            if (accept) begin
                csb_q   <= 1'b0;
                web_q   <= ~bus.req_we[grant_idx];
                wmask_q <= bus.req_wmask[int'(grant_idx)*NUM_WMASKS +: NUM_WMASKS];
                addr_q  <= bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                din_q   <= bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                rd_p0   <= ~bus.req_we[grant_idx];
                id_p0   <= grant_idx;
            end
        end
    end

    // Response stage: SRAM samples one edge later, dout is captured on the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1        <= 1'b0;
            id_p1        <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            rd_p1        <= rd_p0;
            id_p1        <= id_p0;
            resp_valid_q <= rd_p1 ? (NUM_REQ'(1) << id_p1) : '0;
            if (rd_p1) resp_rdata_q <= bus.sram_dout0;
        end
    end

    assign bus.sram_csb0   = csb_q;
    assign bus.sram_web0   = web_q;
    assign bus.sram_wmask0 = wmask_q;
    assign bus.sram_addr0  = addr_q;
    assign bus.sram_din0   = din_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
endmodule
